spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 184 ++++++++++++++++++
 tb/tb_spi_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 master, one WIDTH-bit frame per start, MSB first.
// Optional receive path enabled by defining SPI_CONTROLLER_RX_EN.
module spi_controller #(
  parameter int WIDTH    = 8,
  parameter int DIV_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEAD    = 3'd1;
  localparam logic [2:0] SCLK_HI = 3'd2;
  localparam logic [2:0] SCLK_LO = 3'd3;
  localparam logic [2:0] TRAIL   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH);
  localparam logic [8:0]    HALF_RL  = 9'(DIV_HALF - 1);
  // TRAIL covers the final SCLK low phase plus the chip-select hold phase.
  localparam logic [8:0]    TRAIL_RL = 9'(2 * DIV_HALF - 1);

  logic [2:0]       state_q, state_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             mosi_q, mosi_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             enter_hi, enter_done;
  logic             half_end;

  assign half_end = (cnt_q == 9'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    enter_hi   = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && start) begin
          tx_d    = tx_data;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[WIDTH-1];
          busy_d  = 1'b1;
          cnt_d   = HALF_RL;
          state_d = LEAD;
        end
      end
      LEAD, SCLK_LO: begin
        if (ena) begin
          if (half_end) begin
            enter_hi = 1'b1;
            sclk_d   = 1'b1;
            bit_d    = bit_q + BIT_ONE;
            cnt_d    = HALF_RL;
            state_d  = SCLK_HI;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
      end
      SCLK_HI: begin
        if (ena) begin
          if (half_end) begin
            sclk_d = 1'b0;
            if (bit_q < BIT_LAST) begin
              tx_d    = {tx_q[WIDTH-2:0], 1'b0};
              mosi_d  = tx_q[WIDTH-2];
              cnt_d   = HALF_RL;
              state_d = SCLK_LO;
            end else begin
              cnt_d   = TRAIL_RL;
              state_d = TRAIL;
            end
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
      end
      TRAIL: begin
        if (ena) begin
          if (half_end) begin
            enter_done = 1'b1;
            cs_n_d     = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CONTROLLER_RX_EN
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    if (enter_hi) rx_sh_d = {rx_sh_q[WIDTH-2:0], spi_miso};
    if (enter_done) rx_data_d = rx_sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`else
  logic unused_rx;
  assign unused_rx = spi_miso ^ enter_hi ^ enter_done;
  assign rx_data   = '0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed table-driven bench for spi_controller (WIDTH=8).
module tb_spi_controller;

`ifdef SPI_CONTROLLER_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0] rx_data;
  logic       miso_one = 1'b0;

  logic       b_ena = 1'b0;
  logic       b_start = 1'b0;
  logic       b_busy, b_done, b_sclk, b_cs_n, b_mosi;
  logic [7:0] b_rx;

  assign spi_miso = miso_one ? 1'b1 : spi_mosi;

  always #5 clk = ~clk;

  spi_controller #(.WIDTH(8), .DIV_HALF(2)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_controller #(.WIDTH(8), .DIV_HALF(1)) u_b2b (
    .clk(clk), .rst(rst), .ena(b_ena), .start(b_start), .tx_data(8'h96),
    .busy(b_busy), .done(b_done), .rx_data(b_rx), .spi_sclk(b_sclk),
    .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(b_mosi)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    bit         toggle;
    bit         miso_hi;
    int         cycles;
    logic [7:0] rx;
  } vec_t;

  logic [7:0] r_bits;
  int         r_edges, r_cycles;
  bit         r_done_seen, r_aborted;

  // start_edge/abort_edge: act once this many SCLK rising edges have been seen (0 = never)
  task automatic run_frame(input logic [7:0] tx, input bit toggle, input bit miso_hi,
                           input int start_edge, input int abort_edge);
    bit prev, injected;
    @(negedge clk);
    miso_one = miso_hi;
    tx_data  = tx;
    start    = 1'b1;
    ena      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("cs_low_after_accept", spi_cs_n, 0);
    r_bits = 8'h00; r_edges = 0; r_cycles = 0;
    r_done_seen = 1'b0; r_aborted = 1'b0;
    prev = spi_sclk; injected = 1'b0;
    while (!r_done_seen && r_cycles < 400) begin
      if (toggle) ena = ~ena;
      @(negedge clk);
      r_cycles++;
      start = 1'b0;
      if (!prev && spi_sclk) begin
        r_bits = {r_bits[6:0], spi_mosi};
        r_edges++;
      end
      prev = spi_sclk;
      if (start_edge != 0 && !injected && r_edges == start_edge && !spi_sclk) begin
        start = 1'b1;
        injected = 1'b1;
      end
      if (abort_edge != 0 && r_edges == abort_edge && spi_sclk) begin
        rst = 1'b1;
        #1;
        chk("abort_cs_n", spi_cs_n, 1);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_busy", busy, 0);
        r_aborted = 1'b1;
        break;
      end
      if (done) r_done_seen = 1'b1;
    end
    if (r_aborted) return;
    chk("frame_timeout", r_done_seen, 1);
    chk("done_cs_n", spi_cs_n, 1);
    chk("done_busy", busy, 0);
    ena = toggle ? 1'b0 : 1'b1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    ena = 1'b1;
  endtask

  vec_t vecs[7];
  int   gap, min_gap, frames;
  bit   seen_low, prev_cs, any_done;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 36, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 36, 8'h3C};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 72, 8'hA5};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 72, 8'h3C};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 36, 8'hFF};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 36, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 72, 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    rst = 1'b0;
    ena = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].tx, vecs[i].toggle, vecs[i].miso_hi, 0, 0);
      chk($sformatf("v%0d_bits", i), r_bits, vecs[i].tx);
      chk($sformatf("v%0d_edges", i), r_edges, 8);
      chk($sformatf("v%0d_cycles", i), r_cycles, vecs[i].cycles);
      chk($sformatf("v%0d_rx", i), rx_data, RX ? vecs[i].rx : 8'h00);
    end

    // start re-pulsed during the low phase after bit 3 must be ignored
    run_frame(8'hA5, 1'b0, 1'b0, 3, 0);
    chk("restart_edges", r_edges, 8);
    chk("restart_bits", r_bits, 8'hA5);
    chk("restart_cycles", r_cycles, 36);
    any_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy || !spi_cs_n) any_done = 1'b1;
    end
    chk("restart_no_second_frame", any_done, 0);

    // reset during bit 5 aborts with no done, then a clean frame follows
    run_frame(8'h5A, 1'b0, 1'b0, 0, 5);
    chk("abort_reached", r_aborted, 1);
    any_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy) any_done = 1'b1;
    end
    chk("abort_no_done", any_done, 0);
    run_frame(8'h3C, 1'b0, 1'b0, 0, 0);
    chk("post_abort_bits", r_bits, 8'h3C);
    chk("post_abort_edges", r_edges, 8);
    chk("post_abort_cycles", r_cycles, 36);
    chk("post_abort_rx", rx_data, RX ? 8'h3C : 8'h00);

    // back-to-back frames, DIV_HALF=1, start held high
    b_start = 1'b1;
    b_ena   = 1'b1;
    gap = 0; min_gap = 1000; frames = 0; seen_low = 1'b0;
    prev_cs = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (prev_cs && !b_cs_n) begin
        frames++;
        if (seen_low && gap < min_gap) min_gap = gap;
        seen_low = 1'b1;
      end
      gap = b_cs_n ? gap + 1 : 0;
      prev_cs = b_cs_n;
    end
    chk("b2b_frames_ge4", frames >= 4, 1);
    chk("b2b_gap_ge2", min_gap >= 2 && min_gap < 1000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
